// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: pipeline records, data-bus structs, FSM states.
// MEM_ALIGN_EXC_EN turns on address-alignment exceptions (AdEL/AdES) for word/half accesses.
package mem_access_stage_pkg;

`ifdef MEM_ALIGN_EXC_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2} msize_t;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} mstate_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [31:0] valE;
    logic [31:0] valB;
    logic [4:0]  ExcCode;
  } plr_m;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [31:0] valE;
    logic [4:0]  ExcCode;
  } plr_w;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  // All-zero record: opcode NOP, no destination, no exception.
  localparam plr_w PLR_W_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_req_gen.sv
// Combinational request decode: size, byte strobe, replicated store data and misalignment flag.
module mem_req_gen
  import mem_access_stage_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_val,
  output logic        is_mem,
  output logic        is_load,
  output logic        misalign,
  output msize_t      size,
  output logic [3:0]  strobe,
  output logic [31:0] wdata
);

  always_comb begin
    is_mem   = 1'b1;
    is_load  = 1'b0;
    misalign = 1'b0;
    size     = MSIZE4;
    strobe   = 4'b0000;
    wdata    = store_val;
    case (opcode)
      OP_LW: begin
        is_load  = 1'b1;
        misalign = |addr_lo;
      end
      OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        size     = MSIZE2;
        misalign = addr_lo[0];
      end
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        size    = MSIZE1;
      end
      OP_SW: begin
        strobe   = 4'b1111;
        misalign = |addr_lo;
      end
      OP_SH: begin
        size     = MSIZE2;
        strobe   = 4'b0011 << addr_lo;
        wdata    = {2{store_val[15:0]}};
        misalign = addr_lo[0];
      end
      OP_SB: begin
        size   = MSIZE1;
        strobe = 4'b0001 << addr_lo;
        wdata  = {4{store_val[7:0]}};
      end
      default: is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues data-bus requests, stalls upstream while outstanding, registers r_W.
// Alignment exceptions are built only with MEM_ALIGN_EXC_EN defined (see package).
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  plr_m        r_M,
  input  logic        m_valid,
  input  logic        flush,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        stallM,
  output plr_w        r_W,
  output logic [31:0] badvaddr
);

  mstate_t     state, state_n;
  logic        is_mem, is_load, misalign;
  msize_t      size;
  logic [3:0]  strobe;
  logic [31:0] wdata;
  logic        align_exc, go, req_v, load_w, kill_q, kill_n, bad_set;
  logic [4:0]  exc_code;
  plr_w        rec_w, wrec;

  // Load data is consumed by WriteBack straight off the bus.
  logic unused_rdata;
  assign unused_rdata = ^dresp.data;

  mem_req_gen u_req_gen (
    .opcode    (r_M.opcode),
    .addr_lo   (r_M.valE[1:0]),
    .store_val (r_M.valB),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .misalign  (misalign),
    .size      (size),
    .strobe    (strobe),
    .wdata     (wdata)
  );

  assign align_exc = ALIGN_EN & is_mem & misalign;

  // Upstream exceptions take priority over the local alignment check.
  always_comb begin
    exc_code = 5'd0;
    if (r_M.ExcCode != 5'd0) exc_code = r_M.ExcCode;
    else if (align_exc)      exc_code = is_load ? EXC_ADEL : EXC_ADES;
  end

  assign go = m_valid & is_mem & (exc_code == 5'd0) & ~flush;

  always_comb begin
    rec_w = PLR_W_BUBBLE;
    if (m_valid && !flush) begin
      rec_w.opcode  = r_M.opcode;
      rec_w.funct   = r_M.funct;
      rec_w.dstE    = r_M.dstE;
      rec_w.dstM    = r_M.dstM;
      rec_w.valE    = r_M.valE;
      rec_w.ExcCode = exc_code;
    end
  end

  always_comb begin
    state_n = state;
    kill_n  = kill_q;
    req_v   = 1'b0;
    stallM  = 1'b0;
    load_w  = 1'b0;
    wrec    = rec_w;
    case (state)
      IDLE: begin
        kill_n = 1'b0;
        if (go) begin
          req_v  = 1'b1;
          stallM = 1'b1;
          if (dresp.addr_ok && dresp.data_ok) state_n = DONE;
          else if (dresp.addr_ok)             state_n = DATA;
          else                                state_n = ADDR;
        end else begin
          load_w = 1'b1;
        end
      end
      ADDR: begin
        stallM = 1'b1;
        if (flush) begin
          state_n = IDLE;
        end else begin
          req_v = 1'b1;
          if (dresp.addr_ok && dresp.data_ok) state_n = DONE;
          else if (dresp.addr_ok)             state_n = DATA;
        end
      end
      DATA: begin
        // An accepted request must complete; a flush here only kills the result.
        stallM = 1'b1;
        if (flush)         kill_n  = 1'b1;
        if (dresp.data_ok) state_n = DONE;
      end
      DONE: begin
        load_w  = 1'b1;
        state_n = IDLE;
        if (kill_q) wrec = PLR_W_BUBBLE;
      end
      default: state_n = IDLE;
    endcase
    if (!resetn) begin
      req_v  = 1'b0;
      stallM = 1'b0;
    end
  end

  always_comb begin
    dreq = '0;
    if (req_v) begin
      dreq.valid  = 1'b1;
      dreq.addr   = r_M.valE;
      dreq.size   = size;
      dreq.strobe = strobe;
      dreq.data   = wdata;
    end
  end

  assign bad_set = load_w && (state == IDLE) && m_valid && !flush &&
                   (r_M.ExcCode == 5'd0) && align_exc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      kill_q   <= 1'b0;
      r_W      <= PLR_W_BUBBLE;
      badvaddr <= 32'd0;
    end else begin
      state  <= state_n;
      kill_q <= kill_n;
      if (load_w)  r_W      <= wrec;
      if (bad_set) badvaddr <= r_M.valE;
    end
  end

endmodule
